// File: rtl/psram_burst_reader_pkg.sv
// PSRAM_Utilities: shared PSRAM timing helpers and the burst reader state type.
package PSRAM_Utilities;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, COLLECT, FINISH} reader_state_t;
  function automatic int burst_beats(input int burst);
    return burst / 4;
  endfunction
  // Command-to-command delay: one beat per 4 words plus fixed controller overhead.
  function automatic int burst_delay(input int burst);
    return 11 + burst / 4;
  endfunction
endpackage

// File: rtl/psram_rd_fifo.sv
// psram_rd_fifo: synchronous first-word-fall-through FIFO; push and pop may coincide even when full.
module psram_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    free_cnt
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_pop, w_push;
  assign empty    = r_cnt == '0;
  assign full     = r_cnt == CW'(DEPTH);
  assign free_cnt = CW'(DEPTH) - r_cnt;
  assign pop_data = r_mem[r_rd];
  assign w_pop    = pop & ~empty;
  assign w_push   = push & (~full | w_pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/psram_burst_reader.sv
// psram_burst_reader: issues spaced PSRAM read bursts and streams the returned beats via a FWFT FIFO.
// Optional PSRAM_READER_TIMEOUT_EN adds a collect watchdog and a sticky timeout output.
module psram_burst_reader
  import PSRAM_Utilities::*;
#(
  parameter int BURST      = 16,
  parameter int ADDR_W     = 21,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              calib_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [CNT_W-1:0]  req_bursts,
  output logic              cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [63:0]       rd_data,
  input  logic              rd_data_valid,
  output logic [63:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef PSRAM_READER_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic              done
);
  localparam int BEATS = burst_beats(BURST);
  localparam int GAP   = burst_delay(BURST);
  localparam int BW    = $clog2(BEATS + 1);
  localparam int GW    = $clog2(GAP + 1);
  localparam int FW    = $clog2(FIFO_DEPTH + 1);
  if (BURST != 16 && BURST != 32 && BURST != 64 && BURST != 128) begin : g_bad_burst
    $error("psram_burst_reader: BURST must be 16, 32, 64 or 128");
  end
  if (FIFO_DEPTH < 2 * BEATS) begin : g_bad_depth
    $error("psram_burst_reader: FIFO_DEPTH must be at least 2*BURST/4");
  end
  reader_state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [GW-1:0]     r_gap;
  logic [BW-1:0]     r_beats;
  logic [FW-1:0]     w_free;
  logic w_push, w_burst_end, w_abort, w_full, w_empty;
  assign req_ready   = (r_state == IDLE) & calib_done;
  assign cmd         = 1'b0;
  assign cmd_en      = r_state == ISSUE;
  assign addr        = r_addr;
  assign busy        = r_state != IDLE;
  assign done        = r_state == FINISH;
  assign out_valid   = ~w_empty;
  assign w_push      = (r_state == COLLECT) & rd_data_valid & (r_beats < BW'(BEATS));
  assign w_burst_end = (r_state == COLLECT) & (r_beats == BW'(BEATS)) & (r_gap == '0);
`ifdef PSRAM_READER_TIMEOUT_EN
  logic [9:0] r_wd;
  logic       r_timeout;
  assign timeout = r_timeout;
  assign w_abort = (r_state == COLLECT) & (&r_wd) & (r_beats < BW'(BEATS));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd      <= (r_state == ISSUE) ? '0 : (r_state == COLLECT) ? r_wd + 1'b1 : r_wd;
      r_timeout <= r_timeout | w_abort;
    end
  end
`else
  assign w_abort = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (req_valid & req_ready) ? CHECK : IDLE;
      CHECK:   w_next = (r_rem == '0) ? FINISH :
                        (w_free >= FW'(BEATS) && calib_done) ? ISSUE : CHECK;
      ISSUE:   w_next = COLLECT;
      COLLECT: w_next = w_abort ? FINISH :
                        w_burst_end ? ((r_rem == CNT_W'(1)) ? FINISH : CHECK) : COLLECT;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid && req_ready) begin
        r_addr <= req_addr;
        r_rem  <= req_bursts;
      end
      if (r_state == ISSUE) begin
        r_gap   <= GW'(GAP);
        r_beats <= '0;
      end
      if (r_state == COLLECT && r_gap != '0) r_gap <= r_gap - 1'b1;
      if (w_push) r_beats <= r_beats + 1'b1;
      if (w_burst_end) begin
        r_addr <= r_addr + ADDR_W'(BURST);
        r_rem  <= r_rem - 1'b1;
      end
    end
  end
  psram_rd_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .push_data(rd_data),
    .pop      (out_ready),
    .pop_data (out_data),
    .full     (w_full),
    .empty    (w_empty),
    .free_cnt (w_free)
  );
  logic w_unused;
  assign w_unused = w_full;
endmodule

// File: tb/tb_psram_burst_reader.sv
// tb_psram_burst_reader: directed/randomized checks of the burst reader against an address/word reference model.
module tb_psram_burst_reader;
  localparam int BURST = 16, ADDR_W = 21, FIFO_DEPTH = 64, CNT_W = 16, GAP = 15;
  logic clk = 1'b0, reset, calib_done, req_valid, req_ready, cmd, cmd_en;
  logic out_valid, out_ready, busy, done, rd_data_valid;
  logic [ADDR_W-1:0] req_addr, addr;
  logic [CNT_W-1:0] req_bursts;
  logic [63:0] rd_data, out_data;
`ifdef PSRAM_READER_TIMEOUT_EN
  logic timeout;
`endif
  psram_burst_reader #(.BURST(BURST), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_bursts(req_bursts), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy),
`ifdef PSRAM_READER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .done(done));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, last_cmd = -1000, cmd_cnt = 0, done_cnt = 0, word_cnt = 0;
  int nbeats = 4, rs_wait = 0, rs_beat = 0;
  logic rs_act = 1'b0, rnd_ready = 1'b0;
  logic [ADDR_W-1:0] rs_addr;
  logic [31:0] salt = 32'h0;
  logic [63:0] exp_words[$];
  logic [ADDR_W-1:0] exp_cmds[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] word(input logic [ADDR_W-1:0] a, input int j);
    return {salt, ({11'd0, a} << 2) + 32'(j)};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // Ideal PSRAM: nbeats beats starting ~10 cycles after each command
  initial begin
    rd_data_valid = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_data_valid = 1'b0;
      if (rs_act) begin
        if (rs_wait > 0) rs_wait--;
        else if (rs_beat < nbeats) begin
          rd_data_valid = 1'b1;
          rd_data = word(rs_addr, rs_beat);
          rs_beat++;
        end else rs_act = 1'b0;
      end
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end
  initial forever begin
    @(negedge clk);
    if (cmd_en) begin
      cmd_cnt++;
      if (exp_cmds.size() == 0) chk("cmd_unexpected", 64'(addr), 64'hDEAD);
      else chk("cmd_addr", 64'(addr), 64'(exp_cmds.pop_front()));
      chk("cmd_spacing", 64'(cyc - last_cmd >= GAP + 1), 64'd1);
      last_cmd = cyc;
      rs_act = 1'b1;
      rs_wait = 10;
      rs_beat = 0;
      rs_addr = addr;
    end
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      word_cnt++;
      if (exp_words.size() == 0) chk("word_unexpected", out_data, 64'hDEAD);
      else chk("word", out_data, exp_words.pop_front());
    end
  end
  task automatic request(input logic [ADDR_W-1:0] a, input int n, input int keep);
    logic [ADDR_W-1:0] ka;
    int t = 0;
    salt = $urandom;
    for (int k = 0; k < n; k++) begin
      ka = a + ADDR_W'(k * BURST);
      exp_cmds.push_back(ka);
      for (int j = 0; j < keep; j++) exp_words.push_back(word(ka, j));
    end
    req_addr = a;
    req_bursts = CNT_W'(n);
    req_valid = 1'b1;
    while (!req_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (!req_ready) chk("req_accept_timeout", 64'd0, 64'd1);
    tick(1);
    req_valid = 1'b0;
  endtask
  task automatic wait_done(input int d0, input int limit);
    int t = 0;
    while (done_cnt == d0 && t < limit) begin
      tick(1);
      t++;
    end
    chk("done_pulses", 64'(done_cnt), 64'(d0 + 1));
    t = 0;
    while (exp_words.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    chk("words_left", 64'(exp_words.size()), 64'd0);
    chk("cmds_left", 64'(exp_cmds.size()), 64'd0);
  endtask
  initial begin
    int c0, d0, w0, t;
    reset = 1'b1;
    calib_done = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_bursts = '0;
    out_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_cmd_en", 64'(cmd_en), 64'd0);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req_ready_nocal", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    calib_done = 1'b1;
    tick(1);
    chk("req_ready_cal", 64'(req_ready), 64'd1);
    // three bursts from 0x100
    c0 = cmd_cnt; d0 = done_cnt; w0 = word_cnt;
    request(21'h100, 3, 4);
    wait_done(d0, 200);
    chk("t1_cmds", 64'(cmd_cnt - c0), 64'd3);
    chk("t1_words", 64'(word_cnt - w0), 64'd12);
    // zero-burst request
    c0 = cmd_cnt;
    request(21'h40, 0, 0);
    chk("zero_done_c1", 64'(done), 64'd0);
    tick(1);
    chk("zero_done_c2", 64'(done), 64'd1);
    tick(1);
    chk("zero_done_c3", 64'(done), 64'd0);
    chk("zero_req_ready", 64'(req_ready), 64'd1);
    chk("zero_no_cmd", 64'(cmd_cnt - c0), 64'd0);
    // address wrap
    d0 = done_cnt;
    request(21'h1FFFF0, 2, 4);
    wait_done(d0, 200);
    // surplus beats are dropped
    nbeats = 7;
    d0 = done_cnt;
    request(21'($urandom), 3, 4);
    wait_done(d0, 200);
    nbeats = 4;
    // random requests with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      request(21'($urandom), $urandom_range(1, 5), 4);
      wait_done(d0, 600);
    end
    rnd_ready = 1'b0;
    tick(1);
    out_ready = 1'b1;
    // full FIFO holds further bursts in CHECK
    out_ready = 1'b0;
    c0 = cmd_cnt; d0 = done_cnt;
    request(21'($urandom), 20, 4);
    tick(600);
    chk("bp_cmds_held", 64'(cmd_cnt - c0), 64'd16);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_data", out_data, exp_words[0]);
    out_ready = 1'b1;
    wait_done(d0, 2000);
    chk("bp_cmds_total", 64'(cmd_cnt - c0), 64'd20);
    // calibration loss mid-request
    c0 = cmd_cnt; d0 = done_cnt;
    request(21'($urandom), 3, 4);
    t = 0;
    while (cmd_cnt == c0 && t < 100) begin
      tick(1);
      t++;
    end
    calib_done = 1'b0;
    tick(100);
    chk("cal_cmds_held", 64'(cmd_cnt - c0), 64'd1);
    chk("cal_busy", 64'(busy), 64'd1);
    calib_done = 1'b1;
    wait_done(d0, 300);
    // reset during collection of burst 2 of 4
    c0 = cmd_cnt; d0 = done_cnt;
    request(21'($urandom), 4, 4);
    t = 0;
    while (cmd_cnt < c0 + 2 && t < 200) begin
      tick(1);
      t++;
    end
    tick(12);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_words.delete();
    exp_cmds.delete();
    last_cmd = -1000;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cmd_en", 64'(cmd_en), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_addr", 64'(addr), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    tick(20);
    chk("late_beats_dropped", 64'(out_valid), 64'd0);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    d0 = done_cnt;
    request(21'($urandom), 2, 4);
    wait_done(d0, 300);
`ifdef PSRAM_READER_TIMEOUT_EN
    nbeats = 2;
    d0 = done_cnt; w0 = word_cnt;
    request(21'($urandom), 1, 2);
    tick(900);
    chk("timeout_early", 64'(timeout), 64'd0);
    wait_done(d0, 400);
    chk("timeout_set", 64'(timeout), 64'd1);
    chk("timeout_words", 64'(word_cnt - w0), 64'd2);
    nbeats = 4;
`endif
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
